// File: rtl/ifstmt_reduce_pkg.sv
// Shared definitions for the frame reducer: FSM encoding, operator selectors
// and counter width.
package ifstmt_reduce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int OP_ADD = 0;
  localparam int OP_MUL = 1;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/ifstmt_reduce_alu.sv
// Combinational reduction operator, fixed at elaboration: product when OP
// selects multiply, sum for every other OP value.
module ifstmt_reduce_alu
  import ifstmt_reduce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP    = OP_ADD
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  generate
    if (OP == OP_MUL) begin : g_mul
      assign y = a * b;
    end else begin : g_add
      assign y = a + b;
    end
  endgenerate

endmodule

// File: rtl/ifstmt_reduce.sv
// Frame reducer: folds COUNT operands into one result and holds it on a
// valid/ready output until taken downstream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for first beat of a frame; first beat loads acc
// ST_ACCUM | folding beats 2..COUNT into acc
// ST_HOLD  | result presented; input stalled until result_ready
module ifstmt_reduce
  import ifstmt_reduce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int COUNT = 4,
  parameter int OP    = OP_ADD
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] alu_y;
  logic             beat;

  ifstmt_reduce_alu #(.WIDTH(WIDTH), .OP(OP)) u_alu (
    .a (acc),
    .b (in_data),
    .y (alu_y)
  );

  assign in_ready = (state != ST_HOLD);
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (beat) begin
          acc_nx   = in_data;
          cnt_nx   = CNT_W'(1);
          state_nx = (COUNT == 1) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          acc_nx = alu_y;
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == LAST) state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // result is captured on entry to HOLD so it stays put after the handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      acc          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      acc          <= acc_nx;
      cnt          <= cnt_nx;
      result_valid <= (state_nx == ST_HOLD);
      if (state_nx == ST_HOLD && state != ST_HOLD) result <= acc_nx;
    end
  end

endmodule
